// File: rtl/shr_arb_pkg.sv
// Shared types, defaults and helpers for the shared right-shift arbiter.
package shr_arb_pkg;

   localparam int unsigned N_DEF    = 16;
   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned ID_W     = $clog2(NREQ_DEF);
   localparam int unsigned MAX_NREQ = 8;
   localparam int unsigned ID_MAX_W = 3;

   function automatic logic [MAX_NREQ-1:0] onehot(input logic [ID_MAX_W-1:0] id);
      logic [MAX_NREQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/shr_rr_pick.sv
// Combinational round-robin picker: first requester at or after PTR, wrapping.
module shr_rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] REQ,
   input  logic [IW-1:0]   PTR,
   output logic            GNT_V,
   output logic [IW-1:0]   GNT_ID
);

   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] masked;
   int                idx;

   // The upper copy of REQ covers the indices that wrap past NREQ-1.
   always_comb begin
      dbl    = {REQ, REQ};
      masked = '0;
      for (int j = 0; j < 2 * int'(NREQ); j++) begin
         if (j >= int'(PTR)) masked[j] = dbl[j];
      end
      idx = 0;
      for (int j = 2 * int'(NREQ) - 1; j >= 0; j--) begin
         if (masked[j]) idx = j;
      end
      GNT_V  = |REQ;
      GNT_ID = (idx >= int'(NREQ)) ? IW'(idx - int'(NREQ)) : IW'(idx);
   end

endmodule

// File: rtl/shr_arbiter.sv
// Round-robin arbiter feeding one registered logical right shifter through an
// issue stage and an execute stage; results carry a one-hot requester tag.
module shr_arbiter
   import shr_arb_pkg::*;
#(
   parameter int unsigned N    = N_DEF,
   parameter int unsigned NREQ = NREQ_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [NREQ-1:0]   REQ_R,
   input  logic [NREQ*N-1:0] REQ_D,
   input  logic [NREQ*N-1:0] REQ_S,
   output logic [NREQ-1:0]   REQ_ACK,
   output logic [NREQ-1:0]   RES_R,
   output logic [N-1:0]      RES_D,
   output logic              BUSY
);

   localparam int unsigned IW = $clog2(NREQ);

   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       gnt_id;
   logic                gnt_v;
   logic                s1_v_q, s1_v_d;
   logic [IW-1:0]       s1_id_q, s1_id_d;
   logic [N-1:0]        s1_d_q, s1_d_d;
   logic [N-1:0]        s1_s_q, s1_s_d;
   logic [NREQ-1:0]     res_r_q, res_r_d;
   logic [N-1:0]        res_d_q, res_d_d;
   logic [MAX_NREQ-1:0] gnt_oh, s1_oh;

   shr_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .REQ    (REQ_R),
      .PTR    (ptr_q),
      .GNT_V  (gnt_v),
      .GNT_ID (gnt_id)
   );

   assign gnt_oh  = onehot(ID_MAX_W'(gnt_id));
   assign s1_oh   = onehot(ID_MAX_W'(s1_id_q));
   assign REQ_ACK = (gnt_v && EN && !RST) ? gnt_oh[NREQ-1:0] : '0;
   assign RES_R   = res_r_q;
   assign RES_D   = res_d_q;
   assign BUSY    = s1_v_q | (|res_r_q);

   always_comb begin
      ptr_d   = ptr_q;
      s1_v_d  = s1_v_q;
      s1_id_d = s1_id_q;
      s1_d_d  = s1_d_q;
      s1_s_d  = s1_s_q;
      res_r_d = res_r_q;
      res_d_d = res_d_q;
      if (EN) begin
         s1_v_d = gnt_v;
         if (gnt_v) begin
            ptr_d   = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            s1_id_d = gnt_id;
            s1_d_d  = REQ_D[int'(gnt_id)*N +: N];
            s1_s_d  = REQ_S[int'(gnt_id)*N +: N];
         end
         res_r_d = s1_v_q ? s1_oh[NREQ-1:0] : '0;
         // Amounts of N or more flush every bit out.
         if (s1_v_q) res_d_d = (32'(s1_s_q) >= N) ? '0 : (s1_d_q >> s1_s_q);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q   <= '0;
         s1_v_q  <= 1'b0;
         s1_id_q <= '0;
         s1_d_q  <= '0;
         s1_s_q  <= '0;
         res_r_q <= '0;
         res_d_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         s1_v_q  <= s1_v_d;
         s1_id_q <= s1_id_d;
         s1_d_q  <= s1_d_d;
         s1_s_q  <= s1_s_d;
         res_r_q <= res_r_d;
         res_d_q <= res_d_d;
      end
   end

endmodule

// File: tb/tb_shr_arbiter.sv
// Randomised scoreboard bench for shr_arbiter against a round-robin reference model.
module tb_shr_arbiter;

   localparam int N    = 16;
   localparam int NREQ = 4;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            EN  = 1'b0;
   logic [NREQ-1:0] REQ_R = '1;
   logic [NREQ*N-1:0] REQ_D = '0;
   logic [NREQ*N-1:0] REQ_S = '0;
   logic [NREQ-1:0] REQ_ACK;
   logic [NREQ-1:0] RES_R;
   logic [N-1:0]    RES_D;
   logic            BUSY;

   shr_arbiter #(
      .N    (N),
      .NREQ (NREQ)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .REQ_R   (REQ_R),
      .REQ_D   (REQ_D),
      .REQ_S   (REQ_S),
      .REQ_ACK (REQ_ACK),
      .RES_R   (RES_R),
      .RES_D   (RES_D),
      .BUSY    (BUSY)
   );

   always #5 CLK = ~CLK;

   // cnt = enabled edges seen since the grant cycle; 1 = issue stage, 2 = on output.
   typedef struct {
      int          id;
      logic [15:0] data;
      int          cnt;
   } item_t;

   item_t       sbq[$];
   int          nchecks = 0;
   int          nerrors = 0;
   int          model_ptr = 0;
   bit          prev_en = 1'b0;
   bit          prev_rst = 1'b1;
   bit          mon_on = 1'b0;
   logic [15:0] d_arr[NREQ];
   logic [15:0] s_arr[NREQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] shr_model(input logic [15:0] d, input logic [15:0] s);
      if (s >= 16) return 16'h0;
      return d / (16'd1 << s);
   endfunction

   // One clock cycle: retire the previous edge in the model, drive, check the grant.
   task automatic step(input bit rst, input bit en, input logic [NREQ-1:0] req);
      int g;
      logic [NREQ-1:0] exp_ack;
      @(posedge CLK);
      #1;
      if (prev_rst) begin
         sbq.delete();
         model_ptr = 0;
      end else if (prev_en) begin
         foreach (sbq[i]) sbq[i].cnt++;
      end
      RST   = rst;
      EN    = en;
      REQ_R = req;
      for (int i = 0; i < NREQ; i++) begin
         REQ_D[i*N +: N] = d_arr[i];
         REQ_S[i*N +: N] = s_arr[i];
      end
      #1;
      g = -1;
      if (en && !rst) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(model_ptr + k) % NREQ]) g = (model_ptr + k) % NREQ;
         end
      end
      exp_ack = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ack", 32'(REQ_ACK), 32'(exp_ack));
      if (g >= 0) begin
         sbq.push_back('{id: g, data: shr_model(d_arr[g], s_arr[g]), cnt: 0});
         model_ptr = (g + 1) % NREQ;
      end
      prev_en  = en;
      prev_rst = rst;
   endtask

   logic [NREQ-1:0] mon_exp_r;
   logic            mon_exp_busy;

   always @(negedge CLK) begin
      if (mon_on) begin
         mon_exp_r    = '0;
         mon_exp_busy = 1'b0;
         if (sbq.size() > 0 && sbq[0].cnt >= 2) mon_exp_r = NREQ'(1 << sbq[0].id);
         foreach (sbq[i]) if (sbq[i].cnt >= 1) mon_exp_busy = 1'b1;
         chk("res_r", 32'(RES_R), 32'(mon_exp_r));
         chk("busy", 32'(BUSY), 32'(mon_exp_busy));
         if (mon_exp_r != '0 && EN && RES_R === mon_exp_r) begin
            chk($sformatf("res_d id%0d", sbq[0].id), 32'(RES_D), 32'(sbq[0].data));
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         d_arr[i] = '0;
         s_arr[i] = '0;
      end
      @(posedge CLK);
      mon_on = 1'b1;

      // Reset held with every requester asserting.
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 1'b1, 4'hF);
         chk("reset res_d", 32'(RES_D), 32'h0);
      end

      // All four requesting: expect 0,1,2,3,0,1,2,3 with 0x8000 >> i.
      for (int i = 0; i < NREQ; i++) begin
         d_arr[i] = 16'h8000;
         s_arr[i] = 16'(i);
      end
      for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 4'hF);
      repeat (3) step(1'b0, 1'b1, 4'h0);

      // Requester 2 alone: 0xF0F0 >> 4.
      d_arr[2] = 16'hF0F0;
      s_arr[2] = 16'd4;
      step(1'b0, 1'b1, 4'b0100);
      repeat (3) step(1'b0, 1'b1, 4'h0);

      // Out-of-range and zero shift amounts.
      d_arr[0] = 16'hFFFF; s_arr[0] = 16'd16;
      d_arr[1] = 16'hFFFF; s_arr[1] = 16'hFFFF;
      d_arr[3] = 16'hA5C3; s_arr[3] = 16'd0;
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0010);
      step(1'b0, 1'b1, 4'b1000);
      repeat (3) step(1'b0, 1'b1, 4'h0);

      // Three stalled cycles right after a grant.
      d_arr[1] = 16'h1234; s_arr[1] = 16'd3;
      step(1'b0, 1'b1, 4'b0010);
      repeat (3) step(1'b0, 1'b0, 4'b0010);
      repeat (4) step(1'b0, 1'b1, 4'h0);

      // Reset one cycle after a grant: result dropped, pointer back to 0.
      step(1'b0, 1'b1, 4'b0100);
      step(1'b1, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'hF);
      repeat (3) step(1'b0, 1'b1, 4'h0);

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            d_arr[i] = 16'($urandom);
            s_arr[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
         end
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              NREQ'($urandom_range(0, 15)));
      end
      repeat (4) step(1'b0, 1'b1, 4'h0);
      chk("drained", 32'(sbq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
